// File: rtl/interval_timer_dev.sv
// -----------------------------------------------------------------------------
// interval_timer_dev
//
// Memory-mapped interval timer for the processor I/O bus. It sits beside the
// KEY/SW/HEX/LED devices, downstream of the pipeline register.
//
// Register map (full 32-bit address compare, any other address is ignored):
//   BASE+0  TCNT  tick counter, read/write
//   BASE+4  TLIM  wrap limit, read/write (0 = free-running, no wrap event)
//   BASE+8  TCTL  bit0 READY (sticky, write 0 to clear, write 1 ignored)
//                 bit2 OVR   (sticky, same write rule as READY)
//                 bit4 EN    read/write, enables the prescaler
//                 bit8 IE    read/write, interrupt enable
//                 all other bits read 0
//
// Ports:
//   CLK    processor clock, all state changes on the rising edge
//   reset  synchronous, active-high; clears every register
//   ABUS   registered data address from the pipeline register
//   DBUS   shared tri-state data bus: sampled on stores (WE=1), driven with
//          read data on loads (WE=0) that hit one of the registers, Z otherwise
//   WE     store enable from the pipeline register
//   IRQ    interrupt request level, READY & IE
//
// Parameters:
//   DBITS     bus data/address width
//   BASE      address of TCNT
//   TICK_DIV  CLK cycles per timer tick, 1..65536
// -----------------------------------------------------------------------------
module interval_timer_dev #(
    parameter int unsigned      DBITS    = 32,
    parameter logic [DBITS-1:0] BASE     = 32'hF0000020,
    parameter int unsigned      TICK_DIV = 1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [DBITS-1:0] ABUS,
    inout  wire  [DBITS-1:0] DBUS,
    input  logic             WE,
    output logic             IRQ
);

    // Register indices within the decoded window.
    localparam int NREGS   = 3;
    localparam int IDX_CNT = 0;
    localparam int IDX_LIM = 1;
    localparam int IDX_CTL = 2;

    // TCTL bit positions.
    localparam int BIT_READY = 0;
    localparam int BIT_OVR   = 2;
    localparam int BIT_EN    = 4;
    localparam int BIT_IE    = 8;

    // Prescaler only needs to reach TICK_DIV-1; keep at least one bit so the
    // TICK_DIV=1 case still elaborates (it then sits at 0 and ticks every
    // enabled cycle).
    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [DBITS-1:0] tcnt_reg,  tcnt_next;
    logic [DBITS-1:0] tlim_reg,  tlim_next;
    logic [PRE_W-1:0] pre_reg,   pre_next;
    logic             ready_reg, ready_next;
    logic             ovr_reg,   ovr_next;
    logic             en_reg,    en_next;
    logic             ie_reg,    ie_next;

    // -------------------------------------------------------------------------
    // Address decode: one comparator per register.
    // -------------------------------------------------------------------------
    logic [NREGS-1:0] hit;
    logic [NREGS-1:0] wr_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_dec
            localparam logic [DBITS-1:0] REG_ADDR = BASE + DBITS'(4 * gi);
            assign hit[gi]    = (ABUS == REG_ADDR);
            assign wr_hit[gi] = WE && hit[gi];
        end
    endgenerate

    logic             wr_tcnt;
    logic             wr_tlim;
    logic             wr_tctl;
    logic [DBITS-1:0] wdata;

    assign wr_tcnt = wr_hit[IDX_CNT];
    assign wr_tlim = wr_hit[IDX_LIM];
    assign wr_tctl = wr_hit[IDX_CTL];
    assign wdata   = DBUS;

    // -------------------------------------------------------------------------
    // Read path: AND-OR mux of the register images, driven only on a load hit.
    // -------------------------------------------------------------------------
    logic [DBITS-1:0] tctl_img;
    logic [DBITS-1:0] rd_img   [NREGS];
    logic [DBITS-1:0] rd_term  [NREGS];
    logic [DBITS-1:0] rdata;
    logic             drive_bus;

    always_comb begin
        tctl_img            = '0;
        tctl_img[BIT_READY] = ready_reg;
        tctl_img[BIT_OVR]   = ovr_reg;
        tctl_img[BIT_EN]    = en_reg;
        tctl_img[BIT_IE]    = ie_reg;
    end

    assign rd_img[IDX_CNT] = tcnt_reg;
    assign rd_img[IDX_LIM] = tlim_reg;
    assign rd_img[IDX_CTL] = tctl_img;

    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_rd
            assign rd_term[gi] = hit[gi] ? rd_img[gi] : '0;
        end
    endgenerate

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NREGS; i++) begin
            rdata = rdata | rd_term[i];
        end
    end

    assign drive_bus = !WE && (|hit);
    assign DBUS      = drive_bus ? rdata : {DBITS{1'bz}};

    assign IRQ = ready_reg && ie_reg;

    // -------------------------------------------------------------------------
    // Tick generation and counter update.
    // -------------------------------------------------------------------------
    logic tick;
    logic limit_hit;
    logic wrap;
    logic clr_ready;
    logic clr_ovr;

    always_comb begin
        // EN is sampled pre-edge, so a tick in the cycle that disables the
        // timer still lands.
        tick = en_reg && (pre_reg == PRE_LAST);

        // Limit reached when TCNT >= TLIM-1; a zero limit never wraps.
        limit_hit = (tlim_reg != '0) && (tcnt_reg >= (tlim_reg - DBITS'(1)));

        // A TCNT store swallows a coincident tick, so it can never wrap.
        wrap = tick && !wr_tcnt && limit_hit;

        clr_ready = wr_tctl && !wdata[BIT_READY];
        clr_ovr   = wr_tctl && !wdata[BIT_OVR];
    end

    always_comb begin
        // Prescaler: cleared by a TCNT store, held while disabled.
        pre_next = pre_reg;
        if (wr_tcnt) begin
            pre_next = '0;
        end else if (en_reg) begin
            pre_next = tick ? '0 : (pre_reg + PRE_W'(1));
        end

        // Counter: store wins over tick; otherwise wrap to 0 or increment.
        tcnt_next = tcnt_reg;
        if (wr_tcnt) begin
            tcnt_next = wdata;
        end else if (tick) begin
            tcnt_next = limit_hit ? '0 : (tcnt_reg + DBITS'(1));
        end

        tlim_next = wr_tlim ? wdata : tlim_reg;

        // READY: a wrap always sets it, even against a clearing store, so no
        // event is lost.
        ready_next = ready_reg;
        if (wrap) begin
            ready_next = 1'b1;
        end else if (clr_ready) begin
            ready_next = 1'b0;
        end

        // OVR: a second wrap while READY is still pending. A wrap that races
        // a READY clear is treated as consumed by that clear, not as overrun.
        ovr_next = ovr_reg;
        if (wrap && ready_reg && !clr_ready) begin
            ovr_next = 1'b1;
        end else if (clr_ovr) begin
            ovr_next = 1'b0;
        end

        en_next = wr_tctl ? wdata[BIT_EN] : en_reg;
        ie_next = wr_tctl ? wdata[BIT_IE] : ie_reg;
    end

    // -------------------------------------------------------------------------
    // State register. Reset has priority over any store in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            tcnt_reg  <= '0;
            tlim_reg  <= '0;
            pre_reg   <= '0;
            ready_reg <= 1'b0;
            ovr_reg   <= 1'b0;
            en_reg    <= 1'b0;
            ie_reg    <= 1'b0;
        end else begin
            tcnt_reg  <= tcnt_next;
            tlim_reg  <= tlim_next;
            pre_reg   <= pre_next;
            ready_reg <= ready_next;
            ovr_reg   <= ovr_next;
            en_reg    <= en_next;
            ie_reg    <= ie_next;
        end
    end

endmodule

// File: tb/tb_interval_timer_dev.sv
module tb_interval_timer_dev;

    localparam int          DBITS    = 32;
    localparam logic [31:0] BASE     = 32'hF0000020;
    localparam int          TICK_DIV = 4;

    localparam logic [31:0] A_CNT   = BASE;
    localparam logic [31:0] A_LIM   = BASE + 32'd4;
    localparam logic [31:0] A_CTL   = BASE + 32'd8;
    localparam logic [31:0] A_C     = BASE + 32'hC;
    localparam logic [31:0] A_LOW   = 32'hF0000010;
    // Undriven bus floats to the pull-up level.
    localparam logic [31:0] FLOATED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] abus = '0;
    logic [31:0] wdat = '0;
    tri1  [31:0] dbus;
    logic        irq;

    assign dbus = we ? wdat : 32'hzzzzzzzz;

    always #5 clk = ~clk;

    interval_timer_dev #(
        .DBITS   (DBITS),
        .BASE    (BASE),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .CLK  (clk),
        .reset(rst),
        .ABUS (abus),
        .DBUS (dbus),
        .WE   (we),
        .IRQ  (irq)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] last_rd;
    logic        last_irq;

    // ---------------- reference model ----------------
    // Timer state as described by its register map; m_phase counts enabled
    // cycles since the last TCNT store, modulo TICK_DIV.
    logic [31:0] m_cnt = '0;
    logic [31:0] m_lim = '0;
    bit          m_ready = 0, m_ovr = 0, m_en = 0, m_ie = 0;
    int          m_phase = 0;

    function automatic logic [31:0] model_ctl();
        return (m_ie ? 32'h100 : 32'h0) | (m_en ? 32'h10 : 32'h0) |
               (m_ovr ? 32'h4 : 32'h0) | (m_ready ? 32'h1 : 32'h0);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == A_CNT) return m_cnt;
        if (a == A_LIM) return m_lim;
        if (a == A_CTL) return model_ctl();
        return FLOATED;
    endfunction

    task automatic model_step(input bit r, input bit w, input logic [31:0] a,
                              input logic [31:0] d);
        bit          is_tick, did_wrap, clr;
        logic [31:0] cnt_n;
        if (r) begin
            m_cnt = 0; m_lim = 0; m_ready = 0; m_ovr = 0; m_en = 0; m_ie = 0;
            m_phase = 0;
            return;
        end
        is_tick  = m_en && (m_phase == TICK_DIV - 1);
        did_wrap = 0;
        cnt_n    = m_cnt;
        if (w && a == A_CNT) begin
            cnt_n   = d;
            m_phase = 0;
        end else begin
            if (m_en) m_phase = (m_phase + 1) % TICK_DIV;
            if (is_tick) begin
                if (m_lim != 0 && longint'(m_cnt) >= longint'(m_lim) - 1) begin
                    cnt_n    = 0;
                    did_wrap = 1;
                end else begin
                    cnt_n = 32'((longint'(m_cnt) + 1) % 64'h1_0000_0000);
                end
            end
        end
        clr = w && a == A_CTL && d[0] == 1'b0;
        if (did_wrap && m_ready && !clr) m_ovr = 1;
        else if (w && a == A_CTL && d[2] == 1'b0) m_ovr = 0;
        if (did_wrap) m_ready = 1;
        else if (clr) m_ready = 0;
        if (w && a == A_CTL) begin
            m_en = d[4];
            m_ie = d[8];
        end
        if (w && a == A_LIM) m_lim = d;
        m_cnt = cnt_n;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus transaction: apply inputs, check the load result against the
    // model before the edge, then advance DUT and model together.
    task automatic bus_cycle(input bit r, input bit w, input logic [31:0] a,
                             input logic [31:0] d, input bit chk);
        rst  = r;
        we   = w;
        abus = a;
        wdat = d;
        #2;
        last_rd  = dbus;
        last_irq = irq;
        if (chk && !w && !r) begin
            check("model_rd", last_rd, model_read(a));
            check("model_irq", {31'b0, last_irq}, {31'b0, m_ready && m_ie});
        end
        $display("txn rst=%0b we=%0b addr=%h data=%h bus=%h irq=%0b",
                 r, w, a, d, last_rd, last_irq);
        @(posedge clk);
        model_step(r, w, a, d);
        #1;
    endtask

    task automatic rd_expect(input string name, input logic [31:0] a,
                             input logic [31:0] exp);
        bus_cycle(0, 0, a, '0, 1);
        check(name, last_rd, exp);
    endtask

    task automatic irq_expect(input string name, input bit exp);
        check(name, {31'b0, last_irq}, {31'b0, exp});
    endtask

    task automatic do_reset();
        bus_cycle(1, 0, A_CNT, '0, 0);
        bus_cycle(1, 0, A_CNT, '0, 0);
    endtask

    task automatic start_timer();
        do_reset();
        bus_cycle(0, 1, A_LIM, 32'd3, 0);
        bus_cycle(0, 1, A_CTL, 32'h110, 0);
    endtask

    typedef struct {
        bit          r;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // -------- table-driven: reset state, decode, write masking --------
        tbl[0]  = '{1, 0, A_CNT, 32'h0,          0, 32'h0};
        tbl[1]  = '{0, 0, A_CNT, 32'h0,          1, 32'h0};
        tbl[2]  = '{0, 0, A_LIM, 32'h0,          1, 32'h0};
        tbl[3]  = '{0, 0, A_CTL, 32'h0,          1, 32'h0};
        tbl[4]  = '{0, 0, A_C,   32'h0,          1, FLOATED};
        tbl[5]  = '{0, 0, A_LOW, 32'h0,          1, FLOATED};
        tbl[6]  = '{0, 1, A_LIM, 32'h12345678,   0, 32'h0};
        tbl[7]  = '{0, 0, A_LIM, 32'h0,          1, 32'h12345678};
        tbl[8]  = '{0, 1, A_CTL, 32'hFFFFFFFF,   0, 32'h0};
        tbl[9]  = '{0, 0, A_CTL, 32'h0,          1, 32'h110};
        tbl[10] = '{0, 1, A_CTL, 32'h0,          0, 32'h0};
        tbl[11] = '{0, 0, A_CTL, 32'h0,          1, 32'h0};
        tbl[12] = '{0, 1, A_C,   32'h0000FFFF,   0, 32'h0};
        tbl[13] = '{0, 0, A_LIM, 32'h0,          1, 32'h12345678};

        bus_cycle(1, 0, A_CNT, '0, 0);
        for (int i = 0; i < 14; i++) begin
            bus_cycle(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, 1);
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d", i), last_rd, tbl[i].exp);
                irq_expect($sformatf("tbl%0d_irq", i), 0);
            end
        end

        // -------- sequence A: count to limit, READY, then OVR --------
        start_timer();
        for (int k = 1; k <= 12; k++)
            rd_expect($sformatf("seqA_cnt%0d", k), A_CNT, 32'((k - 1) / 4));
        rd_expect("seqA_ready", A_CTL, 32'h111);
        irq_expect("seqA_irq_rise", 1);
        for (int k = 14; k <= 24; k++)
            rd_expect("seqA_ctl_hold", A_CTL, 32'h111);
        rd_expect("seqA_ovr", A_CTL, 32'h115);
        irq_expect("seqA_irq_ovr", 1);
        bus_cycle(0, 1, A_CTL, 32'h110, 0);
        rd_expect("seqA_clear", A_CTL, 32'h110);
        irq_expect("seqA_irq_clear", 0);

        // -------- sequence B: clear races wrap, TCNT store races tick --------
        start_timer();
        for (int k = 1; k <= 23; k++) bus_cycle(0, 0, A_CNT, '0, 1);
        bus_cycle(0, 1, A_CTL, 32'h110, 0);          // coincides with wrap
        rd_expect("seqB_set_wins", A_CTL, 32'h111);
        irq_expect("seqB_irq", 1);
        bus_cycle(0, 0, A_CNT, '0, 1);
        bus_cycle(0, 0, A_CNT, '0, 1);
        bus_cycle(0, 1, A_CNT, 32'd7, 0);            // coincides with a tick
        for (int k = 0; k < 4; k++) rd_expect("seqB_cnt7", A_CNT, 32'd7);
        rd_expect("seqB_wrap_from7", A_CNT, 32'd0);
        rd_expect("seqB_ovr", A_CTL, 32'h115);

        // -------- sequence C: free-run wrap, then limit below count --------
        do_reset();
        bus_cycle(0, 1, A_CNT, 32'hFFFFFFFE, 0);
        bus_cycle(0, 1, A_CTL, 32'h010, 0);
        for (int k = 0; k < 4; k++) rd_expect("seqC_fffe", A_CNT, 32'hFFFFFFFE);
        for (int k = 0; k < 4; k++) rd_expect("seqC_ffff", A_CNT, 32'hFFFFFFFF);
        rd_expect("seqC_roll", A_CNT, 32'h0);
        rd_expect("seqC_no_ready", A_CTL, 32'h010);
        bus_cycle(0, 1, A_CNT, 32'd9, 0);
        bus_cycle(0, 1, A_LIM, 32'd5, 0);
        for (int k = 0; k < 3; k++) rd_expect("seqC_cnt9", A_CNT, 32'd9);
        rd_expect("seqC_wrap", A_CNT, 32'd0);
        rd_expect("seqC_ready", A_CTL, 32'h011);
        irq_expect("seqC_irq_masked", 0);

        // -------- sequence D: reset mid-count with a coincident store --------
        start_timer();
        for (int k = 1; k <= 20; k++) bus_cycle(0, 0, A_CNT, '0, 1);
        rd_expect("seqD_pre_ctl", A_CTL, 32'h111);
        rd_expect("seqD_pre_cnt", A_CNT, 32'd2);
        bus_cycle(1, 1, A_CNT, 32'd5, 0);
        rd_expect("seqD_cnt", A_CNT, 32'd0);
        rd_expect("seqD_lim", A_LIM, 32'd0);
        rd_expect("seqD_ctl", A_CTL, 32'd0);
        irq_expect("seqD_irq", 0);
        for (int k = 0; k < TICK_DIV; k++) rd_expect("seqD_hold", A_CNT, 32'd0);

        // -------- randomized traffic against the model --------
        do_reset();
        for (int n = 0; n < 500; n++) begin
            int          op;
            logic [31:0] d;
            op = $urandom_range(0, 99);
            d  = $urandom;
            if (op < 2) begin
                bus_cycle(1, $urandom_range(0, 1) == 1, A_CNT, d, 0);
            end else if (op < 10) begin
                bus_cycle(0, 1, A_LIM, 32'($urandom_range(0, 6)), 0);
            end else if (op < 16) begin
                if ($urandom_range(0, 3) == 0)
                    d = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                else
                    d = 32'($urandom_range(0, 8));
                bus_cycle(0, 1, A_CNT, d, 0);
            end else if (op < 24) begin
                d[4] = ($urandom_range(0, 3) != 0);
                bus_cycle(0, 1, A_CTL, d, 0);
            end else begin
                case ($urandom_range(0, 4))
                    0:       bus_cycle(0, 0, A_CNT, '0, 1);
                    1:       bus_cycle(0, 0, A_LIM, '0, 1);
                    2:       bus_cycle(0, 0, A_CTL, '0, 1);
                    3:       bus_cycle(0, 0, A_C, '0, 1);
                    default: bus_cycle(0, 0, A_CNT, '0, 1);
                endcase
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
